fir_out_stage: RTL and testbench
================================

FIR_OUT_STAGE -- requirements
Module: fir_out_stage

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 32: width of the signed accumulator input from the last tap.
REQ-002 SHALL have parameter OUT_WIDTH, default 16: width of the signed output sample.
REQ-003 SHALL have parameter SHIFT, default 15: arithmetic right-shift applied to the accumulator; legal range 0..ACC_WIDTH-1.
REQ-004 SHALL have parameter ROUND, default 1: 1 = round half up, 0 = truncate.
REQ-005 SHALL have parameter FRAME_LEN, default 64: output beats per frame; legal range 1..65535.
REQ-006 SHALL have port clk_i, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port acc_valid_i, input, 1: acc_i holds a new filter result.
REQ-009 SHALL have port acc_i, input, ACC_WIDTH, signed: accumulator value from the tap chain.
REQ-010 SHALL have port acc_ready_o, output, 1: block accepts acc_i this cycle; drives the tap-chain enable upstream.
REQ-011 SHALL have port m_axis_tdata_o, output, OUT_WIDTH, signed: scaled, saturated sample.
REQ-012 SHALL have port m_axis_tvalid_o, output, 1: AXI-Stream valid.
REQ-013 SHALL have port m_axis_tready_i, input, 1: AXI-Stream ready.
REQ-014 SHALL have port m_axis_tlast_o, output, 1: last beat of a frame.
REQ-015 SHALL have port sat_clr_i, input, 1: clears sat_o and sat_cnt_o.
REQ-016 SHALL have port sat_o, output, 1: sticky saturation flag.
REQ-017 SHALL have port sat_cnt_o, output, 16: count of saturated samples.

Function
REQ-018 SHALL accept (push) a sample when acc_valid_i and acc_ready_o are both 1 in the same cycle.
REQ-019 SHALL compute, per pushed sample, r = (acc_i + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT in ACC_WIDTH+1 bits, no intermediate overflow.
REQ-020 SHALL saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; the sample is flagged saturated if clamping changed the value.
REQ-021 SHALL store the result, with its tlast tag, into a 2-entry FIFO; first pushed sample appears on m_axis_tdata_o with tvalid=1 the cycle after push (latency 1).
REQ-022 SHALL pop the head entry when m_axis_tvalid_o and m_axis_tready_i are both 1; output order equals push order.
REQ-023 SHALL hold tdata_o and tlast_o stable while tvalid_o=1 and tready_i=0.
REQ-024 SHALL drive acc_ready_o as a register equal to (FIFO occupancy < 2) for the next cycle; it never depends combinationally on m_axis_tready_i.
REQ-025 SHALL, with occupancy 1 and simultaneous push and pop, keep occupancy 1 (sustained 1 sample/cycle).
REQ-026 SHALL ignore acc_i and acc_valid_i while acc_ready_o=0; no sample is dropped or duplicated.
REQ-027 SHALL count pushes modulo FRAME_LEN and tag tlast=1 on the push at count FRAME_LEN-1, wrapping to 0; FRAME_LEN=1 tags every sample.
REQ-028 SHALL set sat_o on a saturated push; sat_o holds until sat_clr_i.
REQ-029 SHALL increment sat_cnt_o per saturated push, holding at 0xFFFF without wrap.
REQ-030 SHALL, when sat_clr_i coincides with a saturated push, end the cycle with sat_o=1 and sat_cnt_o=1.
REQ-031 SHALL drive m_axis_tdata_o=0 and m_axis_tlast_o=0 whenever m_axis_tvalid_o=0.

Reset
REQ-032 SHALL, on rst_i=1 at a clock edge, empty the FIFO and clear the frame counter; tvalid_o=0, tdata_o=0, tlast_o=0, sat_o=0, sat_cnt_o=0, acc_ready_o=0.
REQ-033 SHALL raise acc_ready_o the first cycle after rst_i deasserts.
REQ-034 SHALL, on reset mid-frame or mid-backpressure, discard held samples; the first post-reset push starts frame count 0.

Verification (defaults: ACC_WIDTH=32, OUT_WIDTH=16, SHIFT=15, ROUND=1)
REQ-035 SHALL cover rounding: push acc 0x00004000, 0xFFFFC000, 0x00003FFF, tready=1 -> tdata 0x0001, 0x0000, 0x0000; sat_o=0.
REQ-036 SHALL cover saturation: push 0x40000000 then 0x80000000 -> tdata 0x7FFF then 0x8000; sat_o=1, sat_cnt_o=2; pulse sat_clr_i -> both 0.
REQ-037 SHALL cover backpressure: tready=0, acc_valid_i=1 with values 1<<15, 2<<15, 3<<15 -> two accepted, acc_ready_o=0; tready=1 -> tdata 1,2,3 in order, none lost.
REQ-038 SHALL cover framing: FRAME_LEN=4, 10 continuous samples, tready=1 -> tlast on beats 3 and 7 only, one beat/cycle after first.
REQ-039 SHALL cover reset mid-operation: 2 held under tready=0, assert rst_i 1 cycle -> tvalid_o=0 next cycle; new sample 5<<15 -> tdata 5, frame count 0.
REQ-040 SHALL cover clear/saturation collision: sat_cnt_o=3, sat_clr_i with push 0x7FFFFFFF -> sat_o=1, sat_cnt_o=1.

Source files
------------

// File: rtl/fir_out_stage.sv
// ============================================================================
// fir_out_stage : scales, rounds and saturates the FIR accumulator, then
//                 streams samples out over AXI-Stream with frame tagging.
// Revision 1.0
// ============================================================================
`default_nettype none

module fir_out_stage #(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 15,
  parameter int ROUND     = 1,
  parameter int FRAME_LEN = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        acc_valid_i,
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  output logic                        acc_ready_o,
  output logic signed [OUT_WIDTH-1:0] m_axis_tdata_o,
  output logic                        m_axis_tvalid_o,
  input  logic                        m_axis_tready_i,
  output logic                        m_axis_tlast_o,
  input  logic                        sat_clr_i,
  output logic                        sat_o,
  output logic [15:0]                 sat_cnt_o
);

  localparam int SUM_W  = ACC_WIDTH + 1;
  localparam int FCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic signed [SUM_W-1:0] RND_ADD =
    (ROUND != 0 && SHIFT > 0) ? (SUM_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic [FCNT_W-1:0] LAST_IDX = FCNT_W'(FRAME_LEN - 1);

  // One extra bit of headroom so the rounding add can never overflow
  logic signed [SUM_W-1:0]     sum;
  logic signed [SUM_W-1:0]     shifted;
  logic signed [OUT_WIDTH-1:0] sample;
  logic                        sample_sat;

  assign sum     = SUM_W'(acc_i) + RND_ADD;
  assign shifted = sum >>> SHIFT;

  generate
    if (OUT_WIDTH < SUM_W) begin : g_sat
      logic [SUM_W-OUT_WIDTH:0] hi;
      assign hi = shifted[SUM_W-1:OUT_WIDTH-1];

      // Value fits only when every bit above the output sign bit matches it
      always_comb begin
        sample     = shifted[OUT_WIDTH-1:0];
        sample_sat = 1'b0;
        if (!((&hi) || (~|hi))) begin
          sample_sat = 1'b1;
          sample     = shifted[SUM_W-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                        : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
      end
    end else begin : g_nosat
      assign sample     = OUT_WIDTH'(shifted);
      assign sample_sat = 1'b0;
    end
  endgenerate

  logic [OUT_WIDTH-1:0] mem_data [2];
  logic                 mem_last [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;
  logic [1:0]           count_next;
  logic [FCNT_W-1:0]    frame_cnt;
  logic                 frame_last;
  logic                 push;
  logic                 pop;
  logic                 sat_push;

  assign push       = acc_valid_i && acc_ready_o;
  assign pop        = (count != 2'd0) && m_axis_tready_i;
  assign frame_last = (frame_cnt == LAST_IDX);
  assign sat_push   = push && sample_sat;
  assign count_next = count + {1'b0, push} - {1'b0, pop};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count       <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      frame_cnt   <= '0;
      acc_ready_o <= 1'b0;
    end else begin
      count       <= count_next;
      // Registered ready keeps tready off the upstream enable path
      acc_ready_o <= (count_next != 2'd2);
      if (push) begin
        wr_ptr    <= ~wr_ptr;
        frame_cnt <= frame_last ? '0 : frame_cnt + FCNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr] <= sample;
      mem_last[wr_ptr] <= frame_last;
    end
  end

  assign m_axis_tvalid_o = (count != 2'd0);
  assign m_axis_tdata_o  = m_axis_tvalid_o ? mem_data[rd_ptr] : '0;
  assign m_axis_tlast_o  = m_axis_tvalid_o ? mem_last[rd_ptr] : 1'b0;

  // A clear that lands on a saturated push restarts the count at one
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sat_o     <= 1'b0;
      sat_cnt_o <= 16'd0;
    end else if (sat_clr_i) begin
      sat_o     <= sat_push;
      sat_cnt_o <= {15'd0, sat_push};
    end else if (sat_push) begin
      sat_o <= 1'b1;
      if (sat_cnt_o != 16'hFFFF) begin
        sat_cnt_o <= sat_cnt_o + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_out_stage.sv
// ============================================================================
// tb_fir_out_stage : directed and random checks of fir_out_stage against a
//                    queue-based reference model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fir_out_stage;

  localparam int AW = 32;
  localparam int OW = 16;
  localparam int SH = 15;
  localparam int RN = 1;
  localparam int FL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          acc_valid;
  logic [AW-1:0] acc;
  logic          acc_ready;
  logic [OW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic          sat_clr;
  logic          sat;
  logic [15:0]   sat_cnt;

  always #5 clk = ~clk;

  fir_out_stage #(
    .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(SH), .ROUND(RN), .FRAME_LEN(FL)
  ) dut (
    .clk_i(clk), .rst_i(rst), .acc_valid_i(acc_valid), .acc_i(acc),
    .acc_ready_o(acc_ready), .m_axis_tdata_o(tdata), .m_axis_tvalid_o(tvalid),
    .m_axis_tready_i(tready), .m_axis_tlast_o(tlast), .sat_clr_i(sat_clr),
    .sat_o(sat), .sat_cnt_o(sat_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of pending beats plus plain counters
  typedef struct packed {
    logic          last;
    logic [OW-1:0] data;
  } beat_t;

  beat_t q[$];
  bit    ready_m;
  int    fidx;
  bit    sat_m;
  int    satcnt_m;

  function automatic void scale(input logic [AW-1:0] a, output logic [OW-1:0] d, output bit s);
    longint v;
    v = longint'($signed(a));
    if (RN != 0 && SH > 0) v = v + (longint'(1) << (SH - 1));
    v = v >>> SH;
    s = 1'b0;
    if (v > 32767) begin
      d = 16'h7FFF; s = 1'b1;
    end else if (v < -32768) begin
      d = 16'h8000; s = 1'b1;
    end else begin
      d = v[15:0];
    end
  endfunction

  task automatic reset_model();
    q.delete();
    fidx     = 0;
    sat_m    = 1'b0;
    satcnt_m = 0;
    ready_m  = 1'b0;
  endtask

  task automatic drive(input bit v, input logic [AW-1:0] a, input bit tr, input bit clr, input bit r);
    acc_valid = v;
    acc       = a;
    tready    = tr;
    sat_clr   = clr;
    rst       = r;
  endtask

  // Called at a falling edge with inputs already applied: checks the state
  // left by the previous rising edge, then advances the model across the next one.
  task automatic cycle();
    bit            push;
    bit            pop;
    bit            s;
    logic [OW-1:0] d;
    beat_t         b;
    check("acc_ready", 64'(acc_ready), 64'(ready_m));
    check("tvalid", 64'(tvalid), 64'(q.size() != 0));
    check("tdata", 64'(tdata), (q.size() != 0) ? 64'(q[0].data) : 64'd0);
    check("tlast", 64'(tlast), (q.size() != 0) ? 64'(q[0].last) : 64'd0);
    check("sat", 64'(sat), 64'(sat_m));
    check("sat_cnt", 64'(sat_cnt), 64'(satcnt_m));
    if (rst) begin
      reset_model();
    end else begin
      push = acc_valid && ready_m;
      pop  = (q.size() != 0) && tready;
      s    = 1'b0;
      if (pop) void'(q.pop_front());
      if (push) begin
        scale(acc, d, s);
        b.data = d;
        b.last = (fidx == FL - 1);
        fidx   = (fidx + 1) % FL;
        q.push_back(b);
      end
      if (sat_clr) begin
        sat_m    = push && s;
        satcnt_m = (push && s) ? 1 : 0;
      end else if (push && s) begin
        sat_m = 1'b1;
        if (satcnt_m < 65535) satcnt_m++;
      end
      ready_m = (q.size() < 2);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic signed [AW-1:0] t;
    drive(0, '0, 0, 0, 1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_model();
    cycle();                          // reset held: all outputs idle
    drive(0, '0, 1, 0, 0); cycle();   // ready rises after reset release
    check("ready_after_rst", 64'(acc_ready), 64'd1);

    // Rounding
    drive(1, 32'h00004000, 1, 0, 0); cycle();
    check("round_a", 64'(tdata), 64'h0001);
    drive(1, 32'hFFFFC000, 1, 0, 0); cycle();
    check("round_b", 64'(tdata), 64'h0000);
    drive(1, 32'h00003FFF, 1, 0, 0); cycle();
    check("round_c", 64'(tdata), 64'h0000);
    check("round_sat", 64'(sat), 64'd0);
    drive(0, '0, 1, 0, 0); cycle();

    // Saturation and clear
    drive(1, 32'h40000000, 1, 0, 0); cycle();
    check("sat_pos", 64'(tdata), 64'h7FFF);
    drive(1, 32'h80000000, 1, 0, 0); cycle();
    check("sat_neg", 64'(tdata), 64'h8000);
    drive(0, '0, 1, 0, 0); cycle();
    check("sat_flag", 64'(sat), 64'd1);
    check("sat_cnt2", 64'(sat_cnt), 64'd2);
    drive(0, '0, 1, 1, 0); cycle();
    check("clr_flag", 64'(sat), 64'd0);
    check("clr_cnt", 64'(sat_cnt), 64'd0);

    // Backpressure
    drive(1, 32'd1 << 15, 0, 0, 0); cycle();
    drive(1, 32'd2 << 15, 0, 0, 0); cycle();
    drive(1, 32'd3 << 15, 0, 0, 0); cycle();
    check("bp_full", 64'(acc_ready), 64'd0);
    check("bp_head", 64'(tdata), 64'd1);
    drive(1, 32'd3 << 15, 1, 0, 0); cycle();
    check("bp_second", 64'(tdata), 64'd2);
    drive(1, 32'd3 << 15, 1, 0, 0); cycle();
    check("bp_third", 64'(tdata), 64'd3);
    drive(0, '0, 1, 0, 0); cycle();
    check("bp_drained", 64'(tvalid), 64'd0);

    // Framing: restart frame count, then 10 back-to-back beats
    drive(0, '0, 1, 0, 1); cycle();
    drive(0, '0, 1, 0, 0); cycle();
    for (int k = 0; k < 10; k++) begin
      drive(1, AW'(k + 10) << 15, 1, 0, 0); cycle();
      check("frame_valid", 64'(tvalid), 64'd1);
      check("frame_data", 64'(tdata), 64'(k + 10));
      check("frame_last", 64'(tlast), 64'((k == 3) || (k == 7)));
    end
    drive(0, '0, 1, 0, 0); cycle();

    // Reset with two samples held under backpressure
    drive(1, 32'd7 << 15, 0, 0, 0); cycle();
    drive(1, 32'd8 << 15, 0, 0, 0); cycle();
    drive(0, '0, 0, 0, 1); cycle();
    check("rst_flush", 64'(tvalid), 64'd0);
    drive(0, '0, 1, 0, 0); cycle();
    drive(1, 32'd5 << 15, 1, 0, 0); cycle();
    check("rst_data", 64'(tdata), 64'd5);
    check("rst_frame0", 64'(tlast), 64'd0);
    for (int k = 0; k < 3; k++) begin
      drive(1, AW'(k) << 15, 1, 0, 0); cycle();
    end
    check("rst_frame_end", 64'(tlast), 64'd1);

    // Clear colliding with a saturated push
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h40000000, 1, 0, 0); cycle();
    end
    check("coll_pre", 64'(sat_cnt), 64'd3);
    drive(1, 32'h7FFFFFFF, 1, 1, 0); cycle();
    check("coll_flag", 64'(sat), 64'd1);
    check("coll_cnt", 64'(sat_cnt), 64'd1);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      t = $signed($urandom());
      drive(($urandom_range(0, 3) != 0), t >>> $urandom_range(0, 20),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 199) == 0));
      cycle();
    end

    // Saturation counter holds at its maximum
    drive(0, '0, 1, 1, 0); cycle();
    for (int k = 0; k < 65540; k++) begin
      drive(1, 32'h80000000, 1, 0, 0); cycle();
    end
    check("cnt_hold", 64'(sat_cnt), 64'hFFFF);
    drive(0, '0, 1, 0, 0); cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
